// File: rtl/key_search_scheduler.sv
// Round-robin key search scheduler: fetches candidate keys from a generator and farms them out to NUM_CORES decryption cores.
// Optional KEY_SEARCH_STATS_EN adds a saturating keys_tried counter; without it keys_tried is tied to zero.
module key_search_scheduler #(
    parameter int NUM_CORES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    search_start,
    output logic                    kg_start,
    input  logic                    kg_finished,
    input  logic                    kg_terminated,
    input  logic [23:0]             kg_key,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [24*NUM_CORES-1:0] core_key,
    input  logic [NUM_CORES-1:0]    core_done,
    input  logic [NUM_CORES-1:0]    core_match,
    output logic                    busy,
    output logic                    found,
    output logic                    exhausted,
    output logic [23:0]             found_key,
    output logic [24:0]             keys_tried
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_KEY,
        DISPATCH,
        DRAIN,
        DONE
    } state_t;

    state_t                  state_reg;
    logic [PTR_W-1:0]        ptr_reg;
    logic [PTR_W-1:0]        ptr_next;
    logic [23:0]             pending_reg;
    logic                    last_seen_reg;
    logic                    kg_start_reg;
    logic                    busy_reg;
    logic                    found_reg;
    logic                    exhausted_reg;
    logic [23:0]             found_key_reg;

    logic [NUM_CORES-1:0]    core_busy;
    logic [NUM_CORES-1:0]    core_start_vec;
    logic [24*NUM_CORES-1:0] core_key_flat;

    logic                    active;
    logic [NUM_CORES-1:0]    match_vec;
    logic                    match_hit;
    logic [23:0]             match_key;
    logic [NUM_CORES-1:0]    rot_idle;
    logic [NUM_CORES-1:0]    first_idle;
    logic [NUM_CORES-1:0]    launch_vec;
    logic                    launch;

    assign active    = (state_reg != IDLE) && (state_reg != DONE);
    // Done pulses from cores we do not consider busy (e.g. abandoned by reset) are dropped here.
    assign match_vec = core_done & core_match & core_busy;
    assign match_hit = active && !found_reg && (|match_vec);
    assign launch    = |launch_vec;

    always_comb begin
        match_key = '0;
        for (int j = NUM_CORES - 1; j >= 0; j--) begin
            if (match_vec[j]) begin
                match_key = core_key_flat[24*j +: 24];
            end
        end
    end

    // Rotate the idle mask so the pointer sits at bit 0, take the lowest idle bit, rotate back.
    always_comb begin
        rot_idle   = NUM_CORES'({~core_busy, ~core_busy} >> ptr_reg);
        first_idle = '0;
        for (int j = NUM_CORES - 1; j >= 0; j--) begin
            if (rot_idle[j]) begin
                first_idle    = '0;
                first_idle[j] = 1'b1;
            end
        end
        launch_vec = '0;
        if (state_reg == DISPATCH && !match_hit) begin
            launch_vec = NUM_CORES'(({first_idle, first_idle} << ptr_reg) >> NUM_CORES);
        end
        ptr_next = ptr_reg;
        for (int j = 0; j < NUM_CORES; j++) begin
            if (launch_vec[j]) begin
                ptr_next = (j == NUM_CORES - 1) ? '0 : PTR_W'(j + 1);
            end
        end
    end

    // Per-core launch pulse, held key and busy bit. Busy is read registered, so a core
    // finishing in a DISPATCH cycle only becomes eligible on the following cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
            logic        busy_bit_reg;
            logic        start_bit_reg;
            logic [23:0] key_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    busy_bit_reg  <= 1'b0;
                    start_bit_reg <= 1'b0;
                    key_reg       <= '0;
                end else begin
                    start_bit_reg <= launch_vec[gi];
                    if (launch_vec[gi]) begin
                        busy_bit_reg <= 1'b1;
                        key_reg      <= pending_reg;
                    end else if (core_done[gi]) begin
                        busy_bit_reg <= 1'b0;
                    end
                end
            end

            assign core_busy[gi]            = busy_bit_reg;
            assign core_start_vec[gi]       = start_bit_reg;
            assign core_key_flat[24*gi +: 24] = key_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            pending_reg   <= '0;
            last_seen_reg <= 1'b0;
            kg_start_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            found_reg     <= 1'b0;
            exhausted_reg <= 1'b0;
            found_key_reg <= '0;
        end else begin
            kg_start_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (search_start) begin
                        state_reg     <= REQ;
                        kg_start_reg  <= 1'b1;
                        busy_reg      <= 1'b1;
                        found_reg     <= 1'b0;
                        exhausted_reg <= 1'b0;
                        found_key_reg <= '0;
                        last_seen_reg <= 1'b0;
                    end
                end
                REQ: begin
                    state_reg <= WAIT_KEY;
                end
                WAIT_KEY: begin
                    if (kg_finished || kg_terminated) begin
                        pending_reg   <= kg_key;
                        last_seen_reg <= kg_terminated;
                        state_reg     <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (launch) begin
                        ptr_reg <= ptr_next;
                        if (last_seen_reg) begin
                            state_reg <= DRAIN;
                        end else begin
                            state_reg    <= REQ;
                            kg_start_reg <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (core_busy == '0) begin
                        state_reg     <= DONE;
                        busy_reg      <= 1'b0;
                        exhausted_reg <= !found_reg;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase

            // A match wins over everything else in the cycle: stop issuing work and drain.
            if (match_hit) begin
                found_reg     <= 1'b1;
                found_key_reg <= match_key;
                state_reg     <= DRAIN;
                kg_start_reg  <= 1'b0;
            end
        end
    end

`ifdef KEY_SEARCH_STATS_EN
    logic [24:0] keys_tried_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keys_tried_reg <= '0;
        end else if (search_start && !active) begin
            keys_tried_reg <= '0;
        end else if (launch && keys_tried_reg != 25'h1FFFFFF) begin
            keys_tried_reg <= keys_tried_reg + 25'd1;
        end
    end

    assign keys_tried = keys_tried_reg;
`else
    assign keys_tried = '0;
`endif

    assign kg_start   = kg_start_reg;
    assign core_start = core_start_vec;
    assign core_key   = core_key_flat;
    assign busy       = busy_reg;
    assign found      = found_reg;
    assign exhausted  = exhausted_reg;
    assign found_key  = found_key_reg;

endmodule

// File: tb/tb_key_search_scheduler.sv
// Directed bench for key_search_scheduler with NUM_CORES=2; the generator and both cores are driven by hand.
module tb_key_search_scheduler;

`ifdef KEY_SEARCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        search_start;
    logic        kg_start;
    logic        kg_finished;
    logic        kg_terminated;
    logic [23:0] kg_key;
    logic [1:0]  core_start;
    logic [47:0] core_key;
    logic [1:0]  core_done;
    logic [1:0]  core_match;
    logic        busy;
    logic        found;
    logic        exhausted;
    logic [23:0] found_key;
    logic [24:0] keys_tried;

    int n_checks = 0;
    int n_fail = 0;
    int kg_pulses = 0;
    int cs_pulses = 0;
    int kg_base;
    int cs_base;

    key_search_scheduler #(.NUM_CORES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .search_start (search_start),
        .kg_start     (kg_start),
        .kg_finished  (kg_finished),
        .kg_terminated(kg_terminated),
        .kg_key       (kg_key),
        .core_start   (core_start),
        .core_key     (core_key),
        .core_done    (core_done),
        .core_match   (core_match),
        .busy         (busy),
        .found        (found),
        .exhausted    (exhausted),
        .found_key    (found_key),
        .keys_tried   (keys_tried)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (kg_start === 1'b1) kg_pulses++;
        if (core_start !== 2'b00) cs_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_kg_start(input string tag);
        int n = 0;
        while (kg_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {63'd0, kg_start}, 64'd1);
    endtask

    // Called with the DUT in REQ: optional done pulses on the REQ edge, then the key on the WAIT_KEY edge.
    task automatic give_key(input logic [23:0] key, input logic last, input logic [1:0] done_mask);
        core_done  = done_mask;
        core_match = 2'b00;
        tick();
        core_done     = 2'b00;
        kg_key        = key;
        kg_finished   = !last;
        kg_terminated = last;
        tick();
        kg_finished   = 1'b0;
        kg_terminated = 1'b0;
    endtask

    task automatic wait_launch(input string tag, input int core, input logic [23:0] key);
        int n = 0;
        logic [47:0] ck;
        while (core_start === 2'b00 && n < 60) begin
            tick();
            n++;
        end
        chk($sformatf("%s_start", tag), {62'd0, core_start}, 64'd1 << core);
        ck = core_key;
        chk($sformatf("%s_key", tag), {40'd0, ck[core*24 +: 24]}, {40'd0, key});
    endtask

    task automatic wait_not_busy(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, {63'd0, busy}, 64'd0);
    endtask

    task automatic start_search();
        search_start = 1'b1;
        tick();
        search_start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; search_start = 1'b0; kg_finished = 1'b0; kg_terminated = 1'b0;
        kg_key = '0; core_done = 2'b00; core_match = 2'b00;
        tick(); tick();
        chk("rst_kg_start", {63'd0, kg_start}, 64'd0);
        chk("rst_core_start", {62'd0, core_start}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_found_exh", {62'd0, found, exhausted}, 64'd0);
        chk("rst_core_key", {16'd0, core_key}, 64'd0);
        reset = 1'b0;
        tick();

        // Range 0..3, no matches: round robin 0,1,0,1 then exhausted.
        kg_base = kg_pulses;
        start_search();
        chk("t1_busy", {63'd0, busy}, 64'd1);
        for (int k = 0; k < 4; k++) begin
            wait_kg_start($sformatf("t1_kg%0d", k));
            give_key(24'(k), k == 3, (k == 0) ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b01 : 2'b10));
            wait_launch($sformatf("t1_launch%0d", k), k % 2, 24'(k));
        end
        core_done = 2'b10;
        tick();
        core_done = 2'b00;
        wait_not_busy("t1_done_busy");
        chk("t1_exhausted", {63'd0, exhausted}, 64'd1);
        chk("t1_found", {63'd0, found}, 64'd0);
        chk("t1_keys_tried", {39'd0, keys_tried}, STATS ? 64'd4 : 64'd0);
        chk("t1_kg_pulses", 64'(kg_pulses - kg_base), 64'd4);

        // Range 0..15, core 1 matches key 5 while core 0 still works on key 6.
        start_search();
        chk("t2_cleared", {62'd0, found, exhausted}, 64'd0);
        for (int k = 0; k < 7; k++) begin
            wait_kg_start($sformatf("t2_kg%0d", k));
            give_key(24'(k), 1'b0, (k == 0 || k == 6) ? 2'b00 : (((k - 1) % 2 == 0) ? 2'b01 : 2'b10));
            wait_launch($sformatf("t2_launch%0d", k), k % 2, 24'(k));
        end
        wait_kg_start("t2_kg7");
        core_done = 2'b10; core_match = 2'b10;
        tick();
        core_done = 2'b00; core_match = 2'b00;
        kg_base = kg_pulses; cs_base = cs_pulses;
        chk("t2_found", {63'd0, found}, 64'd1);
        chk("t2_found_key", {40'd0, found_key}, 64'h5);
        kg_key = 24'h7; kg_finished = 1'b1;
        tick();
        kg_finished = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("t2_still_draining", {63'd0, busy}, 64'd1);
        chk("t2_no_kg_after_match", 64'(kg_pulses - kg_base), 64'd0);
        chk("t2_no_launch_after_match", 64'(cs_pulses - cs_base), 64'd0);
        core_done = 2'b01;
        tick();
        core_done = 2'b00;
        wait_not_busy("t2_done_busy");
        chk("t2_found_exh", {62'd0, found, exhausted}, 64'b10);
        chk("t2_found_key_held", {40'd0, found_key}, 64'h5);
        chk("t2_keys_tried", {39'd0, keys_tried}, STATS ? 64'd7 : 64'd0);

        // Simultaneous matches on keys 6 (core 0) and 7 (core 1): lowest core wins.
        reset = 1'b1; tick(); reset = 1'b0;
        start_search();
        wait_kg_start("t3_kg6");
        give_key(24'h6, 1'b0, 2'b00);
        wait_launch("t3_launch6", 0, 24'h6);
        wait_kg_start("t3_kg7");
        give_key(24'h7, 1'b0, 2'b00);
        wait_launch("t3_launch7", 1, 24'h7);
        core_done = 2'b11; core_match = 2'b11;
        tick();
        core_done = 2'b00; core_match = 2'b00;
        chk("t3_found_key", {40'd0, found_key}, 64'h6);
        wait_not_busy("t3_done_busy");
        chk("t3_found_exh", {62'd0, found, exhausted}, 64'b10);

        // Both cores busy while key 2 is pending for 50 cycles.
        reset = 1'b1; tick(); reset = 1'b0;
        start_search();
        wait_kg_start("t4_kg0");
        give_key(24'h0, 1'b0, 2'b00);
        wait_launch("t4_launch0", 0, 24'h0);
        wait_kg_start("t4_kg1");
        give_key(24'h1, 1'b0, 2'b00);
        wait_launch("t4_launch1", 1, 24'h1);
        wait_kg_start("t4_kg2");
        give_key(24'h2, 1'b0, 2'b00);
        cs_base = cs_pulses;
        for (int i = 0; i < 50; i++) tick();
        chk("t4_no_launch_while_full", 64'(cs_pulses - cs_base), 64'd0);
        core_done = 2'b10;
        tick();
        core_done = 2'b00;
        chk("t4_no_same_cycle_reuse", {62'd0, core_start}, 64'd0);
        tick();
        chk("t4_launch_freed", {62'd0, core_start}, 64'b10);
        chk("t4_launch_key", {40'd0, core_key[47:24]}, 64'h2);

        // Reset while stuck in DISPATCH, then stray done/match and kg pulses.
        wait_kg_start("t5_kg3");
        give_key(24'h3, 1'b0, 2'b00);
        tick();
        reset = 1'b1;
        #1;
        chk("t5_rst_busy", {63'd0, busy}, 64'd0);
        chk("t5_rst_core_key", {16'd0, core_key}, 64'd0);
        chk("t5_rst_outs", {60'd0, kg_start, found, exhausted, |core_start}, 64'd0);
        chk("t5_rst_keys_tried", {39'd0, keys_tried}, 64'd0);
        tick();
        reset = 1'b0;
        core_done = 2'b11; core_match = 2'b11;
        tick();
        core_done = 2'b00; core_match = 2'b00;
        kg_key = 24'h55; kg_terminated = 1'b1;
        tick();
        kg_terminated = 1'b0;
        tick();
        chk("t5_stray_found", {40'd0, found_key}, 64'd0);
        chk("t5_stray_outs", {59'd0, busy, kg_start, found, exhausted, |core_start}, 64'd0);

        // Single-key range 0x00000A..0x00000A.
        kg_base = kg_pulses;
        start_search();
        wait_kg_start("t6_kg");
        give_key(24'h00000A, 1'b1, 2'b00);
        wait_launch("t6_launch", 0, 24'h00000A);
        core_done = 2'b01;
        tick();
        core_done = 2'b00;
        wait_not_busy("t6_done_busy");
        chk("t6_found_exh", {62'd0, found, exhausted}, 64'b01);
        chk("t6_keys_tried", {39'd0, keys_tried}, STATS ? 64'd1 : 64'd0);
        chk("t6_kg_pulses", 64'(kg_pulses - kg_base), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
